// File: rtl/bk_sub_pipe.sv
// rtl/bk_sub_pipe.sv - two-stage pipelined Brent-Kung subtractor, diff = a - b - bin
module bk_sub_pipe #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   input  logic         bin,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] diff,
   output logic         bout,
   output logic         zero,
   output logic         neg,
   output logic         ovf
);
   localparam int LOG = $clog2(W);

   // Up-sweep: node i holds group P/G for the power-of-two span ending at i.
   function automatic logic [2*W-1:0] up_sweep(input logic [W-1:0] p, input logic [W-1:0] g);
      logic [W-1:0] pp, gg;
      pp = p;
      gg = g;
      for (int k = 1; k <= LOG; k++) begin
         for (int i = (1 << k) - 1; i < W; i += (1 << k)) begin
            gg[i] = gg[i] | (pp[i] & gg[i - (1 << (k - 1))]);
            pp[i] = pp[i] & pp[i - (1 << (k - 1))];
         end
      end
      return {pp, gg};
   endfunction

   // Down-sweep fills the remaining nodes so every i holds the prefix [i:0].
   function automatic logic [2*W-1:0] down_sweep(input logic [W-1:0] p, input logic [W-1:0] g);
      logic [W-1:0] pp, gg;
      pp = p;
      gg = g;
      for (int k = LOG - 1; k >= 1; k--) begin
         for (int i = (1 << k) + (1 << (k - 1)) - 1; i < W; i += (1 << k)) begin
            gg[i] = gg[i] | (pp[i] & gg[i - (1 << (k - 1))]);
            pp[i] = pp[i] & pp[i - (1 << (k - 1))];
         end
      end
      return {pp, gg};
   endfunction

   logic [W-1:0] p0, g0, up_p, up_g;
   logic         cin0;

   logic         s1_valid;
   logic [W-1:0] s1_p, s1_gp, s1_gg;
   logic         s1_cin, s1_am, s1_bm;

   logic [W-1:0] pre_p, pre_g, carry, diff_n;
   logic         s1_adv, s2_adv;

   assign p0   = a ^ ~b;
   assign g0   = a & ~b;
   assign cin0 = ~bin;
   assign {up_p, up_g} = up_sweep(p0, g0);

   assign s2_adv   = ~out_valid | out_ready;
   assign s1_adv   = ~s1_valid | s2_adv;
   assign in_ready = s1_adv;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid <= 1'b0;
         s1_p     <= '0;
         s1_gp    <= '0;
         s1_gg    <= '0;
         s1_cin   <= 1'b0;
         s1_am    <= 1'b0;
         s1_bm    <= 1'b0;
      end else if (s1_adv) begin
         s1_valid <= in_valid;
         if (in_valid) begin
            s1_p   <= p0;
            s1_gp  <= up_p;
            s1_gg  <= up_g;
            s1_cin <= cin0;
            s1_am  <= a[W-1];
            s1_bm  <= b[W-1];
         end
      end
   end

   assign {pre_p, pre_g} = down_sweep(s1_gp, s1_gg);
   assign carry  = pre_g | (pre_p & {W{s1_cin}});
   assign diff_n = s1_p ^ {carry[W-2:0], s1_cin};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         diff      <= '0;
         bout      <= 1'b0;
         zero      <= 1'b0;
         neg       <= 1'b0;
         ovf       <= 1'b0;
      end else if (s2_adv) begin
         out_valid <= s1_valid;
         if (s1_valid) begin
            diff <= diff_n;
            bout <= ~carry[W-1];
            zero <= (diff_n == '0);
            neg  <= diff_n[W-1];
            ovf  <= (s1_am != s1_bm) & (diff_n[W-1] != s1_am);
         end
      end
   end
endmodule

// File: tb/tb_bk_sub_pipe.sv
// tb/tb_bk_sub_pipe.sv - self-checking bench for bk_sub_pipe against an arithmetic model
module tb_bk_sub_pipe;
   localparam int W = 16;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         in_valid, in_ready, out_valid, out_ready;
   logic [W-1:0] a, b, diff;
   logic         bin, bout, zero, neg, ovf;

   int errors = 0;
   int checks = 0;
   int n_out  = 0;
   logic [W+3:0] q[$];

   bk_sub_pipe #(.W(W)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .bin(bin), .out_valid(out_valid), .out_ready(out_ready),
      .diff(diff), .bout(bout), .zero(zero), .neg(neg), .ovf(ovf)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   // Packed as {diff, bout, zero, neg, ovf}.
   function automatic logic [W+3:0] model(input logic [W-1:0] ma, input logic [W-1:0] mb, input logic mbi);
      logic [W:0]   full;
      logic [W-1:0] d;
      full = {1'b0, ma} - {1'b0, mb} - {{W{1'b0}}, mbi};
      d    = full[W-1:0];
      return {d, full[W], d == '0, d[W-1], (ma[W-1] != mb[W-1]) && (d[W-1] != ma[W-1])};
   endfunction

   function automatic logic [W+3:0] cur_out();
      return {diff, bout, zero, neg, ovf};
   endfunction

   logic         stalled = 1'b0;
   logic [W+3:0] held;

   always @(negedge clk) begin
      if (!rst_n) begin
         stalled = 1'b0;
      end else begin
         if (stalled) begin
            chk("stall_valid", out_valid, 1'b1);
            chk("stall_hold", cur_out(), held);
         end
         stalled = out_valid && !out_ready;
         held    = cur_out();
         if (out_valid && out_ready) begin
            n_out++;
            if (q.size() == 0) chk("extra_beat", 1, 0);
            else chk("result", cur_out(), q.pop_front());
         end
         if (in_valid && in_ready) q.push_back(model(a, b, bin));
      end
   end

   task automatic put(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tbi);
      int  n;
      bit  done;
      a = ta; b = tb; bin = tbi; in_valid = 1'b1;
      n = 0; done = 0;
      while (!done) begin
         @(negedge clk);
         done = in_ready;
         @(posedge clk); #1;
         n++;
         if (!done && n > 50) begin
            chk("put_timeout", 0, 1);
            done = 1;
         end
      end
      in_valid = 1'b0;
   endtask

   task automatic directed(input string name, input logic [W-1:0] ta, input logic [W-1:0] tb,
                           input logic tbi, input logic [W+3:0] exp);
      put(ta, tb, tbi);
      @(negedge clk);
      @(negedge clk);
      chk({name, "_valid"}, out_valid, 1'b1);
      chk(name, cur_out(), exp);
   endtask

   task automatic drain();
      int n;
      n = 0;
      in_valid = 1'b0;
      out_ready = 1'b1;
      while (q.size() != 0 && n < 200) begin
         @(posedge clk); #1;
         n++;
      end
      chk("drain_empty", q.size(), 0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int accepted, cyc, base;
      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0; bin = 1'b0;

      chk("model_pin_5_3", model(16'h0005, 16'h0003, 1'b0), {16'h0002, 4'b0000});
      chk("model_pin_0_1", model(16'h0000, 16'h0001, 1'b0), {16'hFFFF, 4'b1010});
      chk("model_pin_8000_1", model(16'h8000, 16'h0001, 1'b0), {16'h7FFF, 4'b0001});

      repeat (3) @(posedge clk);
      #1;
      chk("reset_valid", out_valid, 1'b0);
      chk("reset_outs", cur_out(), '0);
      @(posedge clk); #3;
      rst_n = 1'b1;
      @(negedge clk);
      chk("post_reset_in_ready", in_ready, 1'b1);
      @(posedge clk); #1;

      // Directed vectors, including two-register latency on the first one.
      put(16'h0005, 16'h0003, 1'b0);
      @(negedge clk);
      chk("latency_s1", out_valid, 1'b0);
      @(negedge clk);
      chk("latency_s2", out_valid, 1'b1);
      chk("sub_5_3", cur_out(), {16'h0002, 4'b0000});
      @(posedge clk); #1;
      directed("sub_0_1", 16'h0000, 16'h0001, 1'b0, {16'hFFFF, 4'b1010});
      directed("sub_8000_1", 16'h8000, 16'h0001, 1'b0, {16'h7FFF, 4'b0001});
      directed("sub_eq_bin0", 16'h1234, 16'h1234, 1'b0, {16'h0000, 4'b0100});
      directed("sub_eq_bin1", 16'h1234, 16'h1234, 1'b1, {16'hFFFF, 4'b1010});
      drain();

      // Backpressure: two beats fill the pipe, the third is held off.
      base = n_out;
      out_ready = 1'b0;
      put(16'h0100, 16'h0001, 1'b0);
      put(16'h0200, 16'h0002, 1'b1);
      a = 16'h0300; b = 16'h0400; bin = 1'b0; in_valid = 1'b1;
      repeat (3) begin
         @(negedge clk);
         chk("stall_in_ready", in_ready, 1'b0);
         @(posedge clk); #1;
      end
      out_ready = 1'b1;
      put(16'h0300, 16'h0400, 1'b0);
      drain();
      chk("stall_count", n_out - base, 3);

      // Random streaming with random backpressure.
      accepted = 0; cyc = 0;
      while (accepted < 1000 && cyc < 8000) begin
         a = W'($urandom); b = W'($urandom); bin = 1'($urandom);
         if ($urandom_range(0, 7) == 0) b = a;
         in_valid  = ($urandom_range(0, 3) != 0);
         out_ready = ($urandom_range(0, 3) != 0);
         @(negedge clk);
         if (in_valid && in_ready) accepted++;
         @(posedge clk); #1;
         cyc++;
      end
      chk("random_accepted", accepted, 1000);
      drain();

      // Asynchronous reset with two beats in flight.
      out_ready = 1'b0;
      put(16'hAAAA, 16'h5555, 1'b0);
      put(16'h0001, 16'h0002, 1'b1);
      #2;
      rst_n = 1'b0;
      q.delete();
      #1;
      chk("async_rst_valid", out_valid, 1'b0);
      chk("async_rst_outs", cur_out(), '0);
      @(posedge clk); #3;
      rst_n = 1'b1;
      out_ready = 1'b1;
      repeat (4) begin
         @(negedge clk);
         chk("no_stale_valid", out_valid, 1'b0);
         chk("no_stale_in_ready", in_ready, 1'b1);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
